// File: rtl/register_file_param.sv
// register_file_param: parametrised register file with one write port, two
// registered read ports (one-cycle latency, read_valid pulse), optional
// write-to-read bypass, optional hardwired-zero register 0 and a sequenced
// clear-all engine that runs behind busy.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | normal operation: writes, reads and clear requests accepted
// ST_CLEAR | zeroing one register per cycle; all requests ignored
module register_file_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  signal_regwrite,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] output_reg1,
  output logic [DATA_WIDTH-1:0] output_reg2,
  output logic                  read_valid,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]   regs_d [DEPTH];
  logic [DATA_WIDTH-1:0]   out1_q, out1_d;
  logic [DATA_WIDTH-1:0]   out2_q, out2_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   rd1, rd2;
  logic                    wr_ok;

  // Read-port data selection: array value, optionally forwarded write data,
  // forced to zero for a hardwired register 0.
  always_comb begin
    rd1 = regs_q[read_reg1];
    rd2 = regs_q[read_reg2];
    if ((BYPASS != 0) && signal_regwrite && (write_reg == read_reg1)) rd1 = write_data;
    if ((BYPASS != 0) && signal_regwrite && (write_reg == read_reg2)) rd2 = write_data;
    if ((ZERO_REG != 0) && (read_reg1 == '0)) rd1 = '0;
    if ((ZERO_REG != 0) && (read_reg2 == '0)) rd2 = '0;
    wr_ok = signal_regwrite && !((ZERO_REG != 0) && (write_reg == '0));
  end

  // Next-state logic for the FSM, the array and the registered read outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_ok) regs_d[write_reg] = write_data;
        if (read_en) begin
          out1_d  = rd1;
          out2_d  = rd2;
          valid_d = 1'b1;
        end
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset zeroes everything, including an in-flight clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign output_reg1 = out1_q;
  assign output_reg2 = out2_q;
  assign read_valid  = valid_q;
  assign busy        = busy_q;

endmodule
